univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the next generation of the team's 8-bit left/right serial shifter. Adds:
- generic width
- parallel load
- selectable fill mode: serial, rotate, arithmetic, zero
- multi-cycle burst shift of a programmable amount, with a busy/done handshake

Used as a serialiser/deserialiser and as a barrel-shift substitute in datapaths.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst shift amount; max burst = 2**CNT_W-1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
op  in  2  00 hold, 01 single shift, 10 parallel load, 11 burst start
dir  in  1  0 = shift left (toward MSB), 1 = shift right (toward LSB)
fill  in  2  00 serial (si), 01 rotate, 10 arithmetic, 11 zero
si  in  1  serial input bit
din  in  WIDTH  parallel load data
amt  in  CNT_W  burst shift count
q  out  WIDTH  register contents
sol  out  1  q[WIDTH-1]
sor  out  1  q[0]
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (rst=1 at rising edge): q=0, busy=0, done=0, FSM=IDLE, internal count=0. Reset has priority over all ops, including mid-burst; an aborted burst produces no done pulse.
- sol and sor are combinational from q.
- One shift step, left: q <= {q[WIDTH-2:0], f}.
  - fill=00: f=si.
  - fill=01: f=q[WIDTH-1].
  - fill=10: f=0 (arithmetic left equals logical left).
  - fill=11: f=0.
- One shift step, right: q <= {f, q[WIDTH-1:1]}.
  - fill=00: f=si.
  - fill=01: f=q[0].
  - fill=10: f=q[WIDTH-1] (sign replicate).
  - fill=11: f=0.
- FSM states: IDLE, BURST.
- IDLE, op=00: q holds; done=0.
- IDLE, op=01: one shift step at this edge using live dir/fill/si. No busy, no done.
- IDLE, op=10: q <= din at this edge.
- IDLE, op=11, amt=0: no shift. done=1 for the following cycle. Stay IDLE; busy stays 0.
- IDLE, op=11, amt>0 (acceptance edge E0):
  - latch dir and fill into internal registers
  - count <= amt, busy <= 1, go to BURST
  - q unchanged at E0
- BURST, each edge E1..E(amt):
  - one shift step using latched dir/fill and live si (sampled each edge)
  - count decrements
- BURST, edge where count goes 1 -> 0 (E(amt)):
  - final shift performed, FSM -> IDLE, busy <= 0, done <= 1
  - final q and done are visible in the same cycle
- Burst latency: amt+1 edges from acceptance to done.
- In BURST, op, din, amt, dir and fill are ignored; no queuing.
- done is high exactly one cycle; otherwise 0. A new op is accepted in the cycle done is high (FSM already IDLE).
- amt may exceed WIDTH:
  - rotate is periodic in WIDTH
  - zero/serial/arithmetic saturate naturally (e.g. zero fill >= WIDTH steps gives 0)
- All arithmetic on count is unsigned CNT_W bits; no wrap occurs since count stops at 0.

Test Plan:
(WIDTH=8, CNT_W=4)
1. rst=1 one cycle, then op=10 din=8'hA5 -> q=8'hA5, sol=1, sor=1, busy=0, done=0 throughout.
2. From q=8'h00, op=01 dir=0 fill=00 si=1 for 3 cycles -> q=8'h07; then op=01 dir=1 si=0 once -> q=8'h03; no done pulse.
3. Load 8'h81, op=11 dir=1 fill=01 amt=3 -> busy high exactly 3 cycles, done one cycle, q=8'h30. Repeat from 8'h81 with amt=9 -> q=8'hC0 (rotate by 1).
4. Load 8'h90, op=11 dir=1 fill=10 amt=4 -> q=8'hF9 when done. Load 8'h90, dir=0 fill=10 amt=4 -> q=8'h00.
5. op=11 amt=0 -> done=1 next cycle, busy never 1, q unchanged. During a burst (amt=5), drive op=10 din=8'hFF -> ignored, final q reflects shifts only.
6. Start a burst amt=6 and assert rst on the 2nd BURST cycle -> q=8'h00, busy=0, done never pulses. The next cycle's op=10 din=8'h3C is accepted -> q=8'h3C.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for the universal shift register: op/config inputs
// from the master, register contents and burst handshake from the slave.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [1:0]       op;
    logic             dir;
    logic [1:0]       fill;
    logic             si;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             sol;
    logic             sor;
    logic             busy;
    logic             done;

    modport master (
        output op, dir, fill, si, din, amt,
        input  q, sol, sor, busy, done
    );

    modport slave (
        input  op, dir, fill, si, din, amt,
        output q, sol, sor, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, single shift, parallel load and
// multi-cycle burst shift with busy/done handshake and four fill modes.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    univ_shift_reg_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic [1:0]       fill_reg, fill_next;
    logic             done_reg, done_next;

    logic             step_dir;
    logic [1:0]       step_fill;
    logic             fill_bit;
    logic [WIDTH-1:0] shl, shr, step_q;

    // A burst uses the direction/fill captured at acceptance, not the live inputs.
    always_comb begin
        step_dir  = (state_reg == BURST) ? dir_reg  : bus.dir;
        step_fill = (state_reg == BURST) ? fill_reg : bus.fill;
        fill_bit  = 1'b0;
        if (!step_dir) begin
            case (step_fill)
                2'b00:   fill_bit = bus.si;
                2'b01:   fill_bit = q_reg[WIDTH-1];
                default: fill_bit = 1'b0;
            endcase
        end else begin
            case (step_fill)
                2'b00:   fill_bit = bus.si;
                2'b01:   fill_bit = q_reg[0];
                2'b10:   fill_bit = q_reg[WIDTH-1];
                default: fill_bit = 1'b0;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl[gi] = fill_bit;
            end else begin : g_lmid
                assign shl[gi] = q_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr[gi] = fill_bit;
            end else begin : g_rmid
                assign shr[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    assign step_q = step_dir ? shr : shl;

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        fill_next  = fill_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                case (bus.op)
                    2'b01: q_next = step_q;
                    2'b10: q_next = bus.din;
                    2'b11: begin
                        if (bus.amt == '0) begin
                            done_next = 1'b1;
                        end else begin
                            dir_next   = bus.dir;
                            fill_next  = bus.fill;
                            cnt_next   = bus.amt;
                            state_next = BURST;
                        end
                    end
                    default: ;
                endcase
            end
            BURST: begin
                q_next   = step_q;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            fill_reg  <= 2'b00;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            fill_reg  <= fill_next;
            done_reg  <= done_next;
        end
    end

    assign bus.q    = q_reg;
    assign bus.sol  = q_reg[WIDTH-1];
    assign bus.sor  = q_reg[0];
    assign bus.busy = (state_reg == BURST);
    assign bus.done = done_reg;
endmodule
